// File: rtl/crc_frame_arbiter.sv
// crc_frame_arbiter
//   Shares one byte-wise CRC datapath (CRC-16 poly 0x1021, optional CRC-8
//   poly 0x07) between NUM_REQ byte-stream requesters. One requester owns
//   the engine for a whole frame; ownership rotates round-robin. The final
//   remainders are presented with the owner's ID on a valid/ready port.
//
//   Optional feature macro: CRC_ARB_CRC8_EN builds the CRC-8 lane; without
//   it res_crc8 is tied to zero.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   req_valid  [NUM_REQ]     per-requester byte valid
//   req_data   [8*NUM_REQ]   requester i byte at [8i+7:8i]
//   req_last   [NUM_REQ]     final byte of frame (qualified by valid)
//   req_ready  [NUM_REQ]     one-hot grant while a frame runs
//   res_valid / res_ready    result handshake
//   res_id     [IDW]         requester that owns the result
//   res_crc16  [16]          CRC-16 remainder, no final XOR
//   res_crc8   [8]           CRC-8 remainder
//   busy                     high whenever the controller is not idle
module crc_frame_arbiter #(
  parameter int          NUM_REQ = 2,
  parameter logic [15:0] INIT16  = 16'h0000,
  parameter logic [7:0]  INIT8   = 8'h00,
  parameter int          IDW     = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDW-1:0]         res_id,
  output logic [15:0]            res_crc16,
  output logic [7:0]             res_crc8,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] grant, last_grant, pick;
  logic           pick_vld;
  logic           sel_vld, sel_last, accept;
  logic [7:0]     sel_byte;
  logic [15:0]    rem16_p0;

  function automatic logic [15:0] crc16_1021(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int b = 0; b < 8; b++)
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  // Round-robin search starting just after the previous owner.
  always_comb begin
    logic [IDW-1:0] idx;
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  // Byte/valid/last of the current owner.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_vld  = req_valid[i];
        sel_last = req_last[i];
        sel_byte = req_data[8*i +: 8];
      end
    end
  end

  assign accept = (state == RUN) && sel_vld;

  // Handshake outputs depend only on registered state and grant.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (state == RUN) && (grant == IDW'(i));
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_id    = grant;
  assign res_crc16 = rem16_p0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld)            state_nxt = RUN;
      RUN:     if (accept && sel_last)  state_nxt = DONE;
      DONE:    if (res_ready)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage 0: grant bookkeeping and running CRC-16 remainder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      rem16_p0   <= 16'h0000;
    end else begin
      if (state == IDLE && pick_vld) begin
        grant    <= pick;
        rem16_p0 <= INIT16;
      end
      if (accept)
        rem16_p0 <= crc16_1021(rem16_p0, sel_byte);
      if (state == DONE && res_ready)
        last_grant <= grant;
    end
  end

`ifdef CRC_ARB_CRC8_EN
  logic [7:0] rem8_p0;

  function automatic logic [7:0] crc8_07(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++)
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  // Stage 0: running CRC-8 remainder, same sequencing as CRC-16.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem8_p0 <= 8'h00;
    end else begin
      if (state == IDLE && pick_vld)
        rem8_p0 <= INIT8;
      if (accept)
        rem8_p0 <= crc8_07(rem8_p0, sel_byte);
    end
  end

  assign res_crc8 = rem8_p0;
`else
  // INIT8 has no effect when the CRC-8 lane is absent.
  assign res_crc8 = 8'h00 & INIT8;
`endif

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Testbench for crc_frame_arbiter (3 requesters). Stimulus is driven from
// per-requester byte queues; expected results are queued in arbitration order
// and compared by an independent monitor whenever a result handshake occurs.
// The CRC reference uses polynomial long division over the augmented message.
module tb_crc_frame_arbiter;
  localparam int NR  = 3;
  localparam int IDW = 2;
  localparam int NF  = 3;
`ifdef CRC_ARB_CRC8_EN
  localparam bit C8 = 1'b1;
`else
  localparam bit C8 = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [15:0]       res_crc16;
  logic [7:0]        res_crc8;
  logic              busy;

  always #5 clk = ~clk;

  crc_frame_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_crc16(res_crc16), .res_crc8(res_crc8), .busy(busy)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    c16;
    logic [7:0]     c8;
  } exp_t;

  exp_t        exp_q[$];
  logic [12:0] bq [NR][$];   // {gap[3:0], last, data}
  int          gap [NR];
  int          res_mode = 0; // 0: ready high, 1: random, 2: stall 5 cycles
  int          model_last = NR - 1;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] m_crc16(input logic [7:0] m[$]);
    logic [15:0] r;
    logic        top, b;
    r = 16'h0000;
    for (int i = 0; i < m.size()*8 + 16; i++) begin
      b   = (i < m.size()*8) ? m[i/8][7-(i%8)] : 1'b0;
      top = r[15];
      r   = {r[14:0], b};
      if (top) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [7:0] m_crc8(input logic [7:0] m[$]);
    logic [7:0] r;
    logic       top, b;
    r = 8'h00;
    for (int i = 0; i < m.size()*8 + 8; i++) begin
      b   = (i < m.size()*8) ? m[i/8][7-(i%8)] : 1'b0;
      top = r[7];
      r   = {r[6:0], b};
      if (top) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic add_frame(input int r, input string s, input int gap_at, input int gap_len);
    logic [12:0] e;
    for (int i = 0; i < s.len(); i++) begin
      e[7:0]  = s[i];
      e[8]    = (i == s.len() - 1);
      e[12:9] = (i == gap_at) ? 4'(gap_len) : 4'd0;
      bq[r].push_back(e);
    end
  endtask

  task automatic push_exp(input int id, input logic [15:0] c16, input logic [7:0] c8);
    exp_t e;
    e.id  = IDW'(id);
    e.c16 = c16;
    e.c8  = C8 ? c8 : 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_id"},    32'(res_id), 0);
    check({tag, "_crc16"},     32'(res_crc16), 0);
    check({tag, "_crc8"},      32'(res_crc8), 0);
    check({tag, "_busy"},      32'(busy), 0);
  endtask

  task automatic clear_stim();
    for (int r = 0; r < NR; r++) begin
      bq[r].delete();
      gap[r] = 0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #3 reset = 1'b1;
    #1 chk_reset_vals(tag);
    clear_stim();
    @(posedge clk); @(posedge clk); #3 reset = 1'b0;
    model_last = NR - 1;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_timeout"}, 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rnd_round(input int mode);
    logic [15:0] e16 [NR][NF];
    logic [7:0]  e8  [NR][NF];
    logic [7:0]  m[$];
    logic [7:0]  b;
    logic [12:0] e;
    int          len, pend [NR], nxt [NR], total, pk;
    res_mode = mode;
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      for (int f = 0; f < NF; f++) begin
        len = $urandom_range(1, 6);
        m.delete();
        for (int i = 0; i < len; i++) begin
          b       = 8'($urandom);
          e[7:0]  = b;
          e[8]    = (i == len - 1);
          e[12:9] = (i > 0) ? 4'($urandom_range(0, 2)) : 4'd0;
          bq[r].push_back(e);
          m.push_back(b);
        end
        e16[r][f] = m_crc16(m);
        e8[r][f]  = m_crc8(m);
      end
      pend[r] = NF;
      nxt[r]  = 0;
    end
    // All requesters stay pending, so service order is pure rotation
    // over requesters that still have frames.
    total = NR * NF;
    while (total > 0) begin
      pk = 0;
      for (int k = 1; k <= NR; k++) begin
        if (pend[(model_last + k) % NR] > 0) begin
          pk = (model_last + k) % NR;
          break;
        end
      end
      push_exp(pk, e16[pk][nxt[pk]], e8[pk][nxt[pk]]);
      nxt[pk]++;
      pend[pk]--;
      total--;
      model_last = pk;
    end
    wait_empty("rnd", 3000);
    res_mode = 0;
  endtask

  // Stimulus driver: presents queue fronts, advances on accepted bytes.
  initial begin
    logic [NR-1:0] acc;
    logic          rv;
    int            hold;
    hold      = 0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    res_ready = 1'b1;
    for (int r = 0; r < NR; r++) gap[r] = 0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      rv  = res_valid;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (acc[r] && bq[r].size() > 0) begin
          void'(bq[r].pop_front());
          gap[r] = (bq[r].size() > 0) ? int'(bq[r][0][12:9]) : 0;
        end else if (gap[r] > 0) begin
          gap[r]--;
        end
        if (bq[r].size() > 0) begin
          req_valid[r]      = (gap[r] == 0);
          req_data[8*r +: 8] = bq[r][0][7:0];
          req_last[r]       = bq[r][0][8];
        end else begin
          req_valid[r]      = 1'b0;
          req_data[8*r +: 8] = 8'h00;
          req_last[r]       = 1'b0;
        end
      end
      case (res_mode)
        1: res_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!rv) begin
            res_ready = 1'b0;
            hold      = 0;
          end else if (hold < 4) begin
            res_ready = 1'b0;
            hold++;
          end else begin
            res_ready = 1'b1;
          end
        end
        default: res_ready = 1'b1;
      endcase
    end
  end

  // Monitor: ownership, result stability and scoreboard compare.
  initial begin
    exp_t snap, e;
    bit   held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (req_ready != '0) begin
          if (exp_q.size() == 0)
            check("ready_without_frame", 32'(req_ready), 0);
          else
            check("ready_owner", 32'(req_ready), 32'(NR'(1) << exp_q[0].id));
          check("ready_during_result", 32'(res_valid), 0);
        end
        if (res_valid) begin
          check("busy_in_done", 32'(busy), 1);
          if (held) begin
            check("hold_id",    32'(res_id),    32'(snap.id));
            check("hold_crc16", 32'(res_crc16), 32'(snap.c16));
            check("hold_crc8",  32'(res_crc8),  32'(snap.c8));
          end else begin
            snap.id  = res_id;
            snap.c16 = res_crc16;
            snap.c8  = res_crc8;
            held     = 1'b1;
          end
          if (res_ready) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
              check("unexpected_result", 32'(res_valid), 0);
            end else begin
              e = exp_q.pop_front();
              check("res_id",    32'(res_id),    32'(e.id));
              check("res_crc16", 32'(res_crc16), 32'(e.c16));
              check("res_crc8",  32'(res_crc8),  32'(e.c8));
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  // Directed scenarios followed by randomized frames.
  initial begin
    int n, lat, g, s, k;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("por");
    @(posedge clk); #3 reset = 1'b0;

    // Single 9-byte frame: latency and one-cycle result pulse.
    @(negedge clk);
    add_frame(0, "123456789", -1, 0);
    push_exp(0, 16'h31C3, 8'hF4);
    n = 0;
    while (!(req_valid[0] && req_ready[0]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 50);
    check("t1_latency", 32'(lat), 9);
    @(negedge clk);
    check("t1_pulse_width", 32'(res_valid), 0);
    wait_empty("t1", 100);

    // Simultaneous single-byte frames after reset: 0 then 1.
    do_reset("t2_rst");
    @(negedge clk);
    add_frame(0, "1", -1, 0);
    add_frame(1, "1", -1, 0);
    push_exp(0, 16'h2672, 8'h97);
    push_exp(1, 16'h2672, 8'h97);
    wait_empty("t2", 100);

    // Requester 1 waits out requester 0's frame; 2-cycle ready gap.
    @(negedge clk);
    add_frame(0, "123456789", -1, 0);
    add_frame(1, "1", -1, 0);
    push_exp(0, 16'h31C3, 8'hF4);
    push_exp(1, 16'h2672, 8'h97);
    n = 0;
    while (!(req_valid[0] && req_ready[0] && req_last[0]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    g = 0;
    @(negedge clk);
    while (!req_ready[1] && g < 50) begin
      g++;
      @(negedge clk);
    end
    check("t3_ready_gap", 32'(g), 2);
    wait_empty("t3", 100);

    // Result back-pressure for 5 cycles.
    res_mode = 2;
    @(negedge clk);
    add_frame(0, "1", -1, 0);
    push_exp(0, 16'h2672, 8'h97);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    s = 0;
    while (res_valid && !res_ready && s < 50) begin
      s++;
      @(negedge clk);
    end
    check("t4_stall_cycles", 32'(s), 5);
    wait_empty("t4", 100);
    res_mode = 0;

    // Valid gap of 3 cycles inside a frame.
    @(negedge clk);
    add_frame(1, "123456789", 4, 3);
    push_exp(1, 16'h31C3, 8'hF4);
    wait_empty("t5", 100);

    // Reset after the 4th byte, then a fresh frame.
    @(negedge clk);
    add_frame(0, "123456789", -1, 0);
    push_exp(0, 16'h31C3, 8'hF4);
    k = 0;
    n = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) k++;
      n++;
    end
    @(posedge clk); #3 reset = 1'b1;
    #1 chk_reset_vals("t6_rst");
    clear_stim();
    @(posedge clk); @(posedge clk); #3 reset = 1'b0;
    @(negedge clk);
    add_frame(0, "123456789", -1, 0);
    push_exp(0, 16'h31C3, 8'hF4);
    wait_empty("t6", 100);

    // Randomized frames from all requesters.
    do_reset("rnd_rst");
    rnd_round(0);
    rnd_round(1);
    rnd_round(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
